// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master sequencer.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRIME,
    HIGH,
    LOW,
    FINISH
  } spi_state_e;

  localparam int unsigned SPI_DIV_DEFAULT = 5;
  localparam int unsigned SPI_NBITS       = 8;
  localparam int unsigned SPI_SR_LAT      = 3;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI sequencer: counts 0..CLK_DIV-1 while
// enabled, flags the first and the terminal cycle of each half-period.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic first_o,
  output logic tc_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_q;
  logic [7:0] div_cnt_d;

  // Next count: wrap at the terminal value, hold at zero while disabled.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!en_i) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign first_o = (div_cnt_q == '0);
  assign tc_o    = en_i && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: loads an external MOSI shift register, paces
// its shifts, generates SCLK/CS and captures MISO, MSB first.
// Optional feature macro: SPI_IRQ_EN (sticky completion interrupt).
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = SPI_DIV_DEFAULT,
  parameter int unsigned N_BITS  = SPI_NBITS,
  parameter int unsigned SR_LAT  = SPI_SR_LAT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [N_BITS-1:0] tx_data_i,
  input  logic              miso_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] rx_data_o,
  output logic              sr_we_o,
  output logic              sr_shift_o,
  output logic [N_BITS-1:0] sr_data_o,
  output logic              sclk_o,
  output logic              cs_o,
  output logic              irq_o,
  input  logic              irq_clr_i
);

  localparam int unsigned BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);

  // The divider must outlast the shift-register latency so MOSI is settled
  // before each rising SCLK edge.
  if ((CLK_DIV < SR_LAT + 1) || (CLK_DIV > 255)) begin : g_bad_div
    $error("spi_master_ctrl: CLK_DIV out of range");
  end

  spi_state_e        state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [N_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [N_BITS-1:0] rx_data_q, rx_data_d;
  logic [N_BITS-1:0] sr_data_q, sr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic              shift_q, shift_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              div_en, div_first, div_tc;

  assign div_en = (state_q == PRIME) || (state_q == HIGH) || (state_q == LOW);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (div_en),
    .first_o(div_first),
    .tc_o   (div_tc)
  );

  // Next state, bit counter, data capture.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_data_d = sr_data_q;
    rx_sr_d   = rx_sr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = LOAD;
          sr_data_d = tx_data_i;
          bit_cnt_d = BIT_LAST;
        end
      end
      LOAD:  state_d = PRIME;
      PRIME: if (div_tc) state_d = HIGH;
      HIGH: begin
        if (div_first) begin
          rx_sr_d = {rx_sr_q[N_BITS-2:0], miso_i};
        end
        if (div_tc) begin
          state_d = (bit_cnt_q == '0) ? FINISH : LOW;
        end
      end
      LOW: begin
        if (div_tc) begin
          state_d   = HIGH;
          bit_cnt_d = bit_cnt_q - BW'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops
  // and line up with the state they describe.
  always_comb begin
    busy_d    = (state_d != IDLE);
    cs_d      = !((state_d == LOAD) || (state_d == PRIME) ||
                  (state_d == HIGH) || (state_d == LOW));
    sclk_d    = (state_d == HIGH);
    we_d      = (state_d == LOAD);
    shift_d   = ((state_d == PRIME) && (state_q != PRIME)) ||
                ((state_d == LOW)   && (state_q != LOW));
    done_d    = (state_d == FINISH);
    rx_data_d = done_d ? rx_sr_q : rx_data_q;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_data_q <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      shift_q   <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_data_q <= sr_data_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rx_data_o  = rx_data_q;
  assign sr_we_o    = we_q;
  assign sr_shift_o = shift_q;
  assign sr_data_o  = sr_data_q;
  assign sclk_o     = sclk_q;
  assign cs_o       = cs_q;

`ifdef SPI_IRQ_EN
  logic irq_q, irq_d;

  // Sticky interrupt: a completion in the same cycle as a clear wins.
  always_comb begin
    irq_d = irq_q;
    if (done_d) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  // Interrupt flag register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule
